// File: rtl/sipo_pkg.sv
// Shared constants and types for the SIPO deserializer.
//   SIPO_DEFAULT_W : default word width
//   SIPO_MAX_W     : largest supported word width
//   bit_order_e    : serial bit ordering (MSB_FIRST / LSB_FIRST)
package sipo_pkg;

    localparam int unsigned SIPO_DEFAULT_W = 8;
    localparam int unsigned SIPO_MAX_W     = 64;

    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } bit_order_e;

endpackage

// File: rtl/sipo_out_stage.sv
// Output holding register for the SIPO deserializer with valid/ready
// handshake and a sticky overflow flag.
//   clk, rst      : clock, asynchronous active-high reset
//   load          : a new word (full or partial) is offered this cycle
//   load_data     : offered word
//   load_bits     : number of valid bits in the offered word
//   load_partial  : offered word came from a flush with fewer than DATA_W bits
//   out_ready     : consumer accepts data_out this cycle
//   clr_overflow  : clears the overflow flag
//   data_out, out_bits, out_partial, out_valid : held word and qualifiers
//   overflow      : sticky; set when an offered word had to be dropped
module sipo_out_stage #(
    parameter int DATA_W = 8,
    localparam int CNT_W = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CNT_W-1:0]  load_bits,
    input  logic              load_partial,
    input  logic              out_ready,
    input  logic              clr_overflow,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  out_bits,
    output logic              out_partial,
    output logic              out_valid,
    output logic              overflow
);

    logic accept;
    logic drop;
    logic transfer;

    // A word can be taken when the register is empty or is being emptied
    // in this same cycle (no bubble between back-to-back words).
    assign transfer = out_valid & out_ready;
    assign accept   = load & (~out_valid | out_ready);
    assign drop     = load & out_valid & ~out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out    <= '0;
            out_bits    <= '0;
            out_partial <= 1'b0;
            out_valid   <= 1'b0;
        end else if (accept) begin
            data_out    <= load_data;
            out_bits    <= load_bits;
            out_partial <= load_partial;
            out_valid   <= 1'b1;
        end else if (transfer) begin
            out_valid   <= 1'b0;
        end
    end

    // Setting wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer with flush of partial words.
//   CLK, RST      : clock, asynchronous active-high reset
//   shift_enable  : sample serial_in this cycle
//   serial_in     : serial data bit
//   flush         : emit the partial word and clear the accumulator
//   out_ready     : consumer accepts data_out this cycle
//   clr_overflow  : clears the sticky overflow flag
//   data_out      : held output word
//   out_valid     : data_out/out_bits/out_partial are valid
//   out_bits      : number of valid bits in data_out
//   out_partial   : word produced by flush with fewer than DATA_W bits
//   overflow      : sticky; a completed word was dropped
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int DATA_W    = SIPO_DEFAULT_W,
    parameter int LSB_FIRST = 1,
    localparam int CNT_W    = $clog2(DATA_W + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              shift_enable,
    input  logic              serial_in,
    input  logic              flush,
    input  logic              out_ready,
    input  logic              clr_overflow,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic [CNT_W-1:0]  out_bits,
    output logic              out_partial,
    output logic              overflow
);

    localparam bit_order_e ORDER = (LSB_FIRST != 0) ? sipo_pkg::LSB_FIRST
                                                    : sipo_pkg::MSB_FIRST;

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              complete;
    logic              flush_word;
    logic              new_word;
    logic [CNT_W-1:0]  new_bits;

    // The accumulator always holds the received bits right-justified:
    // LSB-first writes bit i at index i, MSB-first shifts in from the bottom
    // so the first bit ends at index cnt-1. A full word then lands at the
    // required positions and a partial word is already right-justified.
    always_comb begin
        acc_next = acc;
        if (shift_enable) begin
            if (ORDER == sipo_pkg::LSB_FIRST) begin
                acc_next = acc | ({{(DATA_W-1){1'b0}}, serial_in} << cnt);
            end else begin
                acc_next = {acc[DATA_W-2:0], serial_in};
            end
        end
    end

    // Flush acts on the count after this cycle's bit has been taken in.
    assign cnt_next   = cnt + CNT_W'(shift_enable);
    assign complete   = shift_enable & (cnt == CNT_W'(DATA_W - 1));
    assign flush_word = flush & ~complete & (cnt_next != '0);
    assign new_word   = complete | flush_word;
    assign new_bits   = complete ? CNT_W'(DATA_W) : cnt_next;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc <= '0;
            cnt <= '0;
        end else if (complete || flush) begin
            acc <= '0;
            cnt <= '0;
        end else if (shift_enable) begin
            acc <= acc_next;
            cnt <= cnt_next;
        end
    end

    sipo_out_stage #(
        .DATA_W (DATA_W)
    ) u_out_stage (
        .clk          (CLK),
        .rst          (RST),
        .load         (new_word),
        .load_data    (acc_next),
        .load_bits    (new_bits),
        .load_partial (flush_word),
        .out_ready    (out_ready),
        .clr_overflow (clr_overflow),
        .data_out     (data_out),
        .out_bits     (out_bits),
        .out_partial  (out_partial),
        .out_valid    (out_valid),
        .overflow     (overflow)
    );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench for sipo_deserializer: 8-bit LSB-first,
// 8-bit MSB-first and 12-bit LSB-first instances share one stimulus.
module tb_sipo_deserializer;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic shift_enable = 1'b0;
    logic serial_in = 1'b0;
    logic flush = 1'b0;
    logic out_ready = 1'b0;
    logic clr_overflow = 1'b0;

    logic [7:0]  a_data;  logic a_valid; logic [3:0] a_bits; logic a_part; logic a_ovf;
    logic [7:0]  b_data;  logic b_valid; logic [3:0] b_bits; logic b_part; logic b_ovf;
    logic [11:0] c_data;  logic c_valid; logic [3:0] c_bits; logic c_part; logic c_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    sipo_deserializer #(.DATA_W(8), .LSB_FIRST(1)) dut_lsb (
        .CLK(CLK), .RST(RST), .shift_enable(shift_enable), .serial_in(serial_in),
        .flush(flush), .out_ready(out_ready), .clr_overflow(clr_overflow),
        .data_out(a_data), .out_valid(a_valid), .out_bits(a_bits),
        .out_partial(a_part), .overflow(a_ovf)
    );

    sipo_deserializer #(.DATA_W(8), .LSB_FIRST(0)) dut_msb (
        .CLK(CLK), .RST(RST), .shift_enable(shift_enable), .serial_in(serial_in),
        .flush(flush), .out_ready(out_ready), .clr_overflow(clr_overflow),
        .data_out(b_data), .out_valid(b_valid), .out_bits(b_bits),
        .out_partial(b_part), .overflow(b_ovf)
    );

    sipo_deserializer #(.DATA_W(12), .LSB_FIRST(1)) dut_w12 (
        .CLK(CLK), .RST(RST), .shift_enable(shift_enable), .serial_in(serial_in),
        .flush(flush), .out_ready(out_ready), .clr_overflow(clr_overflow),
        .data_out(c_data), .out_valid(c_valid), .out_bits(c_bits),
        .out_partial(c_part), .overflow(c_ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic shift_bit(input logic b, input logic fl);
        shift_enable = 1'b1;
        serial_in    = b;
        flush        = fl;
        tick();
        shift_enable = 1'b0;
        flush        = 1'b0;
    endtask

    // Sends the n low bits of w, bit 0 first.
    task automatic send_word(input logic [63:0] w, input int n);
        for (int i = 0; i < n; i++) shift_bit(w[i], 1'b0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_valid", 64'(a_valid), 64'h0);
        check("rst_data",  64'(a_data),  64'h0);
        check("rst_bits",  64'(a_bits),  64'h0);
        check("rst_ovf",   64'(a_ovf),   64'h0);
        do_reset();

        // Full word, both bit orders
        out_ready = 1'b1;
        send_word(64'h0D, 7);
        check("pre_last_valid", 64'(a_valid), 64'h0);
        shift_bit(1'b0, 1'b0);
        check("lsb_data",  64'(a_data),  64'h0D);
        check("lsb_bits",  64'(a_bits),  64'h8);
        check("lsb_valid", 64'(a_valid), 64'h1);
        check("lsb_part",  64'(a_part),  64'h0);
        check("msb_data",  64'(b_data),  64'hB0);
        tick();
        check("valid_pulse", 64'(a_valid), 64'h0);

        // Partial word by flush, then empty flush
        send_word(64'h3, 3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("part_data",  64'(a_data),  64'h03);
        check("part_bits",  64'(a_bits),  64'h3);
        check("part_flag",  64'(a_part),  64'h1);
        check("part_msb",   64'(b_data),  64'h06);
        tick();
        check("part_drop_valid", 64'(a_valid), 64'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("empty_flush", 64'(a_valid), 64'h0);

        // Flush together with a non-completing bit
        send_word(64'h1, 2);
        shift_bit(1'b1, 1'b1);
        check("fs_data", 64'(a_data), 64'h05);
        check("fs_bits", 64'(a_bits), 64'h3);
        check("fs_part", 64'(a_part), 64'h1);
        tick();

        // Overflow with consumer stalled
        do_reset();
        out_ready = 1'b0;
        send_word(64'hAA, 8);
        check("ovf_first_data", 64'(a_data), 64'hAA);
        check("ovf_first_flag", 64'(a_ovf),  64'h0);
        send_word(64'h55, 8);
        check("ovf_hold_data", 64'(a_data), 64'hAA);
        check("ovf_set",       64'(a_ovf),  64'h1);
        send_word(64'h0F, 7);
        clr_overflow = 1'b1;
        shift_bit(1'b0, 1'b0);
        clr_overflow = 1'b0;
        check("ovf_set_wins", 64'(a_ovf), 64'h1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("ovf_clear", 64'(a_ovf), 64'h0);
        check("ovf_held_valid", 64'(a_valid), 64'h1);
        out_ready = 1'b1;
        tick();
        check("xfer_drop_valid", 64'(a_valid), 64'h0);

        // Back-to-back words, ready only as the second completes
        do_reset();
        out_ready = 1'b0;
        send_word(64'h3C, 8);
        check("b2b_first", 64'(a_data), 64'h3C);
        send_word(64'hC3, 7);
        check("b2b_hold_valid", 64'(a_valid), 64'h1);
        check("b2b_hold_data",  64'(a_data),  64'h3C);
        out_ready = 1'b1;
        shift_bit(1'b1, 1'b0);
        check("b2b_second",     64'(a_data),  64'hC3);
        check("b2b_valid",      64'(a_valid), 64'h1);
        check("b2b_no_ovf",     64'(a_ovf),   64'h0);
        tick();
        check("b2b_done", 64'(a_valid), 64'h0);

        // Reset mid-word and with a word pending
        do_reset();
        send_word(64'h1F, 5);
        #2 RST = 1'b1;
        #1;
        check("mid_rst_valid", 64'(a_valid), 64'h0);
        RST = 1'b0;
        tick();
        send_word(64'h5A, 8);
        check("clean_data", 64'(a_data), 64'h5A);
        check("clean_bits", 64'(a_bits), 64'h8);
        out_ready = 1'b0;
        tick();
        send_word(64'h12, 8);
        check("pend_ovf", 64'(a_ovf), 64'h1);
        #2 RST = 1'b1;
        #1;
        check("pend_rst_valid", 64'(a_valid), 64'h0);
        check("pend_rst_data",  64'(a_data),  64'h0);
        check("pend_rst_ovf",   64'(a_ovf),   64'h0);
        RST = 1'b0;
        tick();

        // 12-bit instance: flush on the 12th bit yields a full word
        out_ready = 1'b1;
        send_word(64'hABC, 11);
        shift_bit(1'b1, 1'b1);
        check("w12_data",  64'(c_data),  64'hABC);
        check("w12_bits",  64'(c_bits),  64'hC);
        check("w12_part",  64'(c_part),  64'h0);
        check("w12_valid", 64'(c_valid), 64'h1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
